sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/falcon_pkg.sv | 6 +
 rtl/arb_tag_fifo.sv | 47 ++++
 rtl/sdram_arbiter.sv | 146 ++++++++++++++
 tb/tb_sdram_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/falcon_pkg.sv
// Shared bus geometry for the SDRAM path: address, data and byte-strobe widths.
package falcon_pkg;
  localparam int unsigned ADDR_W = 26;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
endpackage

// File: rtl/arb_tag_fifo.sv
// Circular FIFO of requester tags for reads outstanding at the SDRAM controller.
module arb_tag_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  // Explicit wrap so non-power-of-two depths still cycle modulo DEPTH.
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty  = (count == '0);
  assign do_pop = pop && !empty;
  assign head   = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= bump(wr_ptr);
      if (do_pop) rd_ptr <= bump(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/sdram_arbiter.sv
// Multi-port SDRAM command arbiter: video port priority with burst cap,
// round-robin for the rest, and in-order read-return routing via a tag FIFO.
module sdram_arbiter
  import falcon_pkg::*;
#(
  parameter int unsigned NREQ          = 4,
  parameter int unsigned TAGQ_DEPTH    = 4,
  parameter int unsigned VGA_BURST_MAX = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  input  logic [NREQ*STRB_W-1:0]   req_wstrb,
  output logic [NREQ-1:0]          req_ack,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic                     mem_write,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic [STRB_W-1:0]        mem_wstrb,
  input  logic                     mem_rvalid,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     tag_error
);
  localparam int unsigned IDX_W   = $clog2(NREQ);
  localparam int unsigned CNT_W   = $clog2(TAGQ_DEPTH + 1);
  localparam int unsigned OCC_W   = CNT_W + 1;
  localparam int unsigned BURST_W = $clog2(VGA_BURST_MAX + 1);

  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   rr_pick;
  logic [IDX_W-1:0]   cand;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   mem_port;
  logic [IDX_W-1:0]   q_head;
  logic [CNT_W-1:0]   q_count;
  logic [BURST_W-1:0] burst_cnt;
  logic [NREQ-1:0]    elig;
  logic               rr_found;
  logic               grant_any;
  logic               cmd_free;
  logic               held_read;
  logic               q_full;
  logic               q_empty;
  logic               q_push;
  logic               q_pop;
  logic               other_elig;
  logic               force_rr;

  function automatic logic [IDX_W-1:0] rr_cand(input logic [IDX_W-1:0] last, input int unsigned k);
    int unsigned c;
    c = (32'(last) + k - 1) % (NREQ - 1) + 1;
    return IDX_W'(c);
  endfunction

  assign cmd_free  = !mem_valid || mem_ready;
  assign held_read = mem_valid && !mem_write;
  // The read sitting in the command register already owns a slot; a same-cycle
  // pop only frees space from the following cycle.
  assign q_full     = (OCC_W'(q_count) + OCC_W'(held_read)) >= OCC_W'(TAGQ_DEPTH);
  assign elig       = req_valid & (req_write | {NREQ{!q_full}});
  assign other_elig = |elig[NREQ-1:1];
  assign force_rr   = (burst_cnt >= BURST_W'(VGA_BURST_MAX)) && other_elig;

  always_comb begin
    rr_pick  = '0;
    rr_found = 1'b0;
    cand     = '0;
    for (int unsigned k = 1; k < NREQ; k++) begin
      cand = rr_cand(rr_ptr, k);
      if (!rr_found && elig[cand]) begin
        rr_found = 1'b1;
        rr_pick  = cand;
      end
    end
  end

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    req_ack   = '0;
    if (cmd_free && !reset) begin
      if (elig[0] && !force_rr) begin
        grant_any = 1'b1;
      end else if (rr_found) begin
        grant_any = 1'b1;
        grant_idx = rr_pick;
      end
    end
    if (grant_any) req_ack[grant_idx] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_valid <= 1'b0;
      rr_ptr    <= IDX_W'(NREQ - 1);
      burst_cnt <= '0;
      tag_error <= 1'b0;
    end else begin
      if (cmd_free) mem_valid <= grant_any;
      if (grant_any && grant_idx != '0) rr_ptr <= grant_idx;
      if (!other_elig || (grant_any && grant_idx != '0)) burst_cnt <= '0;
      else if (grant_any)                                 burst_cnt <= burst_cnt + BURST_W'(1);
      if (mem_rvalid && q_empty) tag_error <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (grant_any) begin
      mem_port  <= grant_idx;
      mem_write <= req_write[grant_idx];
      mem_addr  <= req_addr[grant_idx*ADDR_W +: ADDR_W];
      mem_wdata <= req_wdata[grant_idx*DATA_W +: DATA_W];
      mem_wstrb <= req_wstrb[grant_idx*STRB_W +: STRB_W];
    end
  end

  assign q_push = mem_valid && mem_ready && !mem_write;
  assign q_pop  = mem_rvalid && !reset;

  arb_tag_fifo #(
    .DEPTH (TAGQ_DEPTH),
    .WIDTH (IDX_W)
  ) u_tag_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (q_push),
    .push_data (mem_port),
    .pop       (q_pop),
    .head      (q_head),
    .empty     (q_empty),
    .count     (q_count)
  );

  always_comb begin
    rsp_valid = '0;
    if (q_pop && !q_empty) rsp_valid[q_head] = 1'b1;
  end

  assign rsp_rdata = mem_rdata;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: table of per-cycle vectors plus hand-built
// burst-cap, stall and reset sequences.
module tb_sdram_arbiter;
  import falcon_pkg::*;

  localparam int unsigned NREQ = 4;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        req_valid, req_write, req_ack, rsp_valid;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ*STRB_W-1:0] req_wstrb;
  logic [DATA_W-1:0]      rsp_rdata, mem_wdata, mem_rdata;
  logic                   mem_valid, mem_ready, mem_write, mem_rvalid, tag_error;
  logic [ADDR_W-1:0]      mem_addr;
  logic [STRB_W-1:0]      mem_wstrb;

  sdram_arbiter #(.NREQ(NREQ), .TAGQ_DEPTH(4), .VGA_BURST_MAX(4)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ack(req_ack),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .tag_error(tag_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [3:0]  v, w;
    logic        rdy, rv;
    logic [31:0] rd;
    logic [3:0]  e_ack;
    logic        e_mv;
    int          e_port;
    logic [3:0]  e_rsp;
  } vec_t;

  vec_t        tbl[$];
  int unsigned n_vec, n_bad;

  function automatic logic [ADDR_W-1:0] port_addr(input int p);
    return ADDR_W'(32'h0010_0000 * (p + 1) + p * 4);
  endfunction

  function automatic logic [31:0] port_wdata(input int p);
    return 32'hC0DE_0000 + 32'(p);
  endfunction

  function automatic void add(input string name, input logic [3:0] v, w, input logic rdy, rv,
                              input logic [31:0] rd, input logic [3:0] e_ack, input logic e_mv,
                              input int e_port, input logic [3:0] e_rsp);
    vec_t t;
    t.name = name; t.v = v; t.w = w; t.rdy = rdy; t.rv = rv; t.rd = rd;
    t.e_ack = e_ack; t.e_mv = e_mv; t.e_port = e_port; t.e_rsp = e_rsp;
    tbl.push_back(t);
  endfunction

  task automatic step(input logic rst, input logic [3:0] v, w, input logic rdy, rv,
                      input logic [31:0] rd);
    @(posedge clock);
    #1;
    reset = rst; req_valid = v; req_write = w;
    mem_ready = rdy; mem_rvalid = rv; mem_rdata = rd;
    @(negedge clock);
  endtask

  task automatic chk(input string name, input logic [31:0] act, exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_cycle(input string name, input logic [3:0] e_ack, input logic e_mv,
                           input int e_port, input logic [3:0] e_rsp, input logic [31:0] e_rd);
    chk({name, " ack"}, 32'(req_ack), 32'(e_ack));
    chk({name, " mem_valid"}, 32'(mem_valid), 32'(e_mv));
    if (e_mv) begin
      chk({name, " mem_addr"}, 32'(mem_addr), 32'(port_addr(e_port)));
      chk({name, " mem_wdata"}, mem_wdata, port_wdata(e_port));
    end
    chk({name, " rsp_valid"}, 32'(rsp_valid), 32'(e_rsp));
    if (e_rsp != 4'b0) chk({name, " rsp_rdata"}, rsp_rdata, e_rd);
  endtask

  function automatic logic [3:0] onehot(input int p);
    logic [3:0] r;
    r = '0;
    r[p] = 1'b1;
    return r;
  endfunction

  function automatic int burst_grant(input int k);
    return (k % 5 == 4) ? 2 : 0;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ea, er;
    logic       emv;
    int         ep;

    n_vec = 0; n_bad = 0;
    reset = 1'b1; req_valid = '0; req_write = '0; req_wstrb = '1;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    for (int p = 0; p < NREQ; p++) begin
      req_addr[p*ADDR_W +: ADDR_W]  = port_addr(p);
      req_wdata[p*DATA_W +: DATA_W] = port_wdata(p);
    end

    // reset state, then round-robin writes 1,2,3,1,2
    add("reset",  4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 4'b0000);
    add("rr 1",   4'b1110, 4'b1110, 1, 0, 0, 4'b0010, 0, 0, 4'b0000);
    add("rr 2",   4'b1110, 4'b1110, 1, 0, 0, 4'b0100, 1, 1, 4'b0000);
    add("rr 3",   4'b1110, 4'b1110, 1, 0, 0, 4'b1000, 1, 2, 4'b0000);
    add("rr 4",   4'b1110, 4'b1110, 1, 0, 0, 4'b0010, 1, 3, 4'b0000);
    add("rr 5",   4'b1110, 4'b1110, 1, 0, 0, 4'b0100, 1, 1, 4'b0000);
    add("rr 6",   4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 1, 2, 4'b0000);
    add("rr 7",   4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 0, 0, 4'b0000);
    // reads from 2,0,1 returned in order
    add("ret 1",  4'b0100, 4'b0000, 1, 0, 0,            4'b0100, 0, 0, 4'b0000);
    add("ret 2",  4'b0001, 4'b0000, 1, 0, 0,            4'b0001, 1, 2, 4'b0000);
    add("ret 3",  4'b0010, 4'b0000, 1, 0, 0,            4'b0010, 1, 0, 4'b0000);
    add("ret 4",  4'b0000, 4'b0000, 1, 1, 32'hAAAA0001, 4'b0000, 1, 1, 4'b0100);
    add("ret 5",  4'b0000, 4'b0000, 1, 1, 32'hAAAA0002, 4'b0000, 0, 0, 4'b0001);
    add("ret 6",  4'b0000, 4'b0000, 1, 1, 32'hAAAA0003, 4'b0000, 0, 0, 4'b0010);
    add("ret 7",  4'b0000, 4'b0000, 1, 0, 0,            4'b0000, 0, 0, 4'b0000);
    // fill tag queue with four port-0 reads; port 1 read blocked, port 3 write passes
    add("full 1", 4'b0001, 4'b0000, 1, 0, 0,            4'b0001, 0, 0, 4'b0000);
    add("full 2", 4'b0001, 4'b0000, 1, 0, 0,            4'b0001, 1, 0, 4'b0000);
    add("full 3", 4'b0001, 4'b0000, 1, 0, 0,            4'b0001, 1, 0, 4'b0000);
    add("full 4", 4'b0001, 4'b0000, 1, 0, 0,            4'b0001, 1, 0, 4'b0000);
    add("full 5", 4'b1010, 4'b1000, 1, 0, 0,            4'b1000, 1, 0, 4'b0000);
    add("full 6", 4'b0010, 4'b0000, 1, 0, 0,            4'b0000, 1, 3, 4'b0000);
    add("full 7", 4'b0010, 4'b0000, 1, 0, 0,            4'b0000, 0, 0, 4'b0000);
    add("full 8", 4'b0010, 4'b0000, 1, 1, 32'hBBBB0001, 4'b0000, 0, 0, 4'b0001);
    add("full 9", 4'b0010, 4'b0000, 1, 0, 0,            4'b0010, 0, 0, 4'b0000);
    add("drain1", 4'b0000, 4'b0000, 1, 1, 32'hBBBB0002, 4'b0000, 1, 1, 4'b0001);
    add("drain2", 4'b0000, 4'b0000, 1, 1, 32'hBBBB0003, 4'b0000, 0, 0, 4'b0001);
    add("drain3", 4'b0000, 4'b0000, 1, 1, 32'hBBBB0004, 4'b0000, 0, 0, 4'b0001);
    add("drain4", 4'b0000, 4'b0000, 1, 1, 32'hBBBB0005, 4'b0000, 0, 0, 4'b0010);
    add("drain5", 4'b0000, 4'b0000, 1, 0, 0,            4'b0000, 0, 0, 4'b0000);

    repeat (2) @(posedge clock);
    step(1'b1, '0, '0, 1'b0, 1'b0, '0);
    foreach (tbl[i]) begin
      step(1'b0, tbl[i].v, tbl[i].w, tbl[i].rdy, tbl[i].rv, tbl[i].rd);
      chk_cycle(tbl[i].name, tbl[i].e_ack, tbl[i].e_mv, tbl[i].e_port, tbl[i].e_rsp, tbl[i].rd);
      chk({tbl[i].name, " tag_error"}, 32'(tag_error), 32'h0);
    end

    // video burst cap: ports 0 and 2 reading continuously, returns two cycles after grant
    for (int k = 0; k < 17; k++) begin
      step(1'b0, (k < 15) ? 4'b0101 : 4'b0000, 4'b0000, 1'b1, k >= 2, 32'hCC00_0000 + 32'(k));
      ea  = (k < 15) ? onehot(burst_grant(k)) : 4'b0000;
      emv = (k >= 1 && k <= 15);
      ep  = emv ? burst_grant(k - 1) : 0;
      er  = (k >= 2) ? onehot(burst_grant(k - 2)) : 4'b0000;
      chk_cycle($sformatf("burst %0d", k), ea, emv, ep, er, 32'hCC00_0000 + 32'(k));
    end

    // controller stall: fields held, one ack only
    step(1'b0, 4'b0010, 4'b0010, 1'b0, 1'b0, '0);
    chk_cycle("stall ack", 4'b0010, 1'b0, 0, 4'b0000, '0);
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 4'b0010, 4'b0010, 1'b0, 1'b0, '0);
      chk_cycle($sformatf("stall hold %0d", k), 4'b0000, 1'b1, 1, 4'b0000, '0);
      chk($sformatf("stall write %0d", k), 32'(mem_write), 32'h1);
    end
    step(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, '0);
    chk_cycle("stall release", 4'b0000, 1'b1, 1, 4'b0000, '0);

    // two reads outstanding, then reset discards them
    step(1'b0, 4'b0010, 4'b0000, 1'b1, 1'b0, '0);
    chk_cycle("pre-reset rd a", 4'b0010, 1'b0, 0, 4'b0000, '0);
    step(1'b0, 4'b0010, 4'b0000, 1'b1, 1'b0, '0);
    chk_cycle("pre-reset rd b", 4'b0010, 1'b1, 1, 4'b0000, '0);
    step(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, '0);
    chk_cycle("pre-reset rd c", 4'b0000, 1'b1, 1, 4'b0000, '0);
    step(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 32'hDEAD_0001);
    chk("rsp during reset", 32'(rsp_valid), 32'h0);
    step(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 32'hDEAD_0002);
    chk("post-reset mem_valid", 32'(mem_valid), 32'h0);
    chk("post-reset rsp", 32'(rsp_valid), 32'h0);
    chk("post-reset tag_error", 32'(tag_error), 32'h0);
    step(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, '0);
    chk("tag_error set", 32'(tag_error), 32'h1);
    chk("tag_error mem_valid", 32'(mem_valid), 32'h0);
    step(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, '0);
    chk("tag_error sticky", 32'(tag_error), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
